// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, instruction field positions and FSM state type shared by the core.
package cpu_pkg;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_LW  = 2'b01;
    localparam logic [1:0] OP_SW  = 2'b10;
    localparam logic [1:0] OP_J   = 2'b11;
    localparam int OP_HI  = 7;
    localparam int OP_LO  = 6;
    localparam int RS_HI  = 5;
    localparam int RS_LO  = 4;
    localparam int RT_HI  = 3;
    localparam int RT_LO  = 2;
    localparam int RD_HI  = 1;
    localparam int RD_LO  = 0;
    localparam int IMM_HI = 1;
    localparam int IMM_LO = 0;
    localparam int OFF_HI = 5;
    localparam int OFF_LO = 0;
    typedef enum logic [1:0] {ST_FETCH, ST_EXEC, ST_MEM} state_t;
endpackage

// File: rtl/cpu_dmem.sv
// cpu_dmem: data memory with synchronous write, registered read and
// reset initialisation of every word to its own index.
module cpu_dmem #(
    parameter int DATA_W     = 8,
    parameter int DMEM_DEPTH = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          i_we,
    input  logic [$clog2(DMEM_DEPTH)-1:0] i_addr,
    input  logic [DATA_W-1:0]             i_wdata,
    output logic [DATA_W-1:0]             o_rdata
);
    logic [DATA_W-1:0] r_mem [DMEM_DEPTH];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DMEM_DEPTH; i++) r_mem[i] <= DATA_W'(i);
            r_rdata <= '0;
        end else begin
            if (i_we) r_mem[i_addr] <= i_wdata;
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/param_cpu_core.sv
// param_cpu_core: 4-register multi-cycle core (FETCH/EXEC/MEM) with ADD, LW, SW and J;
// register file and FSM live here, data memory is cpu_dmem.
module param_cpu_core
    import cpu_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 8,
    parameter int DMEM_DEPTH = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [7:0]        Instruction,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [ADDR_W-1:0] read_address,
    input  logic [1:0]        reg_sel,
    output logic [DATA_W-1:0] reg_out,
    output logic              retire
);
    localparam int AW = $clog2(DMEM_DEPTH);

    state_t            r_state, w_next;
    logic [7:0]        r_ir;
    logic [ADDR_W-1:0] r_pc;
    logic [DATA_W-1:0] r_regs [4];
    logic [1:0]        w_op, w_rs, w_rt, w_rd, w_wsel;
    logic [DATA_W-1:0] w_sum, w_rdata, w_wdata;
    logic [AW-1:0]     w_maddr;
    logic [ADDR_W-1:0] w_pc_next;
    logic              w_reg_we, w_mem_we, w_pc_en, w_retire;

    assign w_op  = r_ir[OP_HI:OP_LO];
    assign w_rs  = r_ir[RS_HI:RS_LO];
    assign w_rt  = r_ir[RT_HI:RT_LO];
    assign w_rd  = r_ir[RD_HI:RD_LO];
    assign w_sum = r_regs[w_rs] + r_regs[w_rt];
    assign w_maddr = AW'(r_regs[w_rs] + DATA_W'($signed(r_ir[IMM_HI:IMM_LO])));
    assign w_pc_next = r_pc + ADDR_W'(1)
                     + (w_op == OP_J ? ADDR_W'($signed(r_ir[OFF_HI:OFF_LO])) : '0);

    always_comb begin
        w_next   = r_state;
        w_reg_we = 1'b0;
        w_mem_we = 1'b0;
        w_pc_en  = 1'b0;
        w_retire = 1'b0;
        w_wsel   = w_rd;
        w_wdata  = w_sum;
        case (r_state)
            ST_FETCH: w_next = instr_valid ? ST_EXEC : ST_FETCH;
            ST_EXEC: begin
                w_next   = (w_op == OP_LW) ? ST_MEM : ST_FETCH;
                w_reg_we = (w_op == OP_ADD);
                w_mem_we = (w_op == OP_SW);
                w_pc_en  = (w_op != OP_LW);
                w_retire = (w_op != OP_LW);
            end
            ST_MEM: begin
                w_next   = ST_FETCH;
                w_reg_we = 1'b1;
                w_wsel   = w_rt;
                w_wdata  = w_rdata;
                w_pc_en  = 1'b1;
                w_retire = 1'b1;
            end
            default: w_next = ST_FETCH;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) r_state <= ST_FETCH;
        else       r_state <= w_next;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc <= '0;
            r_ir <= '0;
            for (int i = 0; i < 4; i++) r_regs[i] <= DATA_W'(i);
        end else begin
            if (r_state == ST_FETCH && instr_valid) r_ir <= Instruction;
            if (w_pc_en) r_pc <= w_pc_next;
            if (w_reg_we) r_regs[w_wsel] <= w_wdata;
        end
    end

    // Store data is R[rt]; the same address feeds the registered LW read.
    cpu_dmem #(.DATA_W(DATA_W), .DMEM_DEPTH(DMEM_DEPTH)) u_dmem (
        .clock   (clock),
        .reset   (reset),
        .i_we    (w_mem_we),
        .i_addr  (w_maddr),
        .i_wdata (r_regs[w_rt]),
        .o_rdata (w_rdata)
    );

    assign instr_ready  = (r_state == ST_FETCH);
    assign read_address = r_pc;
    assign reg_out      = r_regs[reg_sel];
    assign retire       = w_retire & ~reset;
endmodule

// File: tb/tb_param_cpu_core.sv
// tb_param_cpu_core: scoreboard bench; a reference model pushes expected retire
// latency, PC and registers per instruction, popped when the core retires.
module tb_param_cpu_core;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        instr_valid = 1'b0;
    logic [7:0]  Instruction = 8'h00;
    logic [1:0]  reg_sel = 2'd0;
    logic        instr_ready, retire, instr_ready16, retire16;
    logic [7:0]  read_address, read_address16, reg_out;
    logic [15:0] reg_out16;

    int n_cmp = 0;
    int n_err = 0;
    int m_r [4];
    int m_mem [32];
    int m_pc;

    typedef struct packed {
        int              lat;
        int              pc;
        logic [3:0][7:0] r;
    } exp_t;
    exp_t sb [$];

    param_cpu_core u_dut (
        .clock(clock), .reset(reset), .Instruction(Instruction), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .read_address(read_address), .reg_sel(reg_sel),
        .reg_out(reg_out), .retire(retire)
    );

    param_cpu_core #(.DATA_W(16)) u_dut16 (
        .clock(clock), .reset(reset), .Instruction(Instruction), .instr_valid(instr_valid),
        .instr_ready(instr_ready16), .read_address(read_address16), .reg_sel(reg_sel),
        .reg_out(reg_out16), .retire(retire16)
    );

    always #10 clock = ~clock;

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_r[i] = i;
        for (int i = 0; i < 32; i++) m_mem[i] = i;
        m_pc = 0;
    endtask

    task automatic model_step(input logic [7:0] ins, output exp_t e);
        int op  = int'(ins[7:6]);
        int rs  = int'(ins[5:4]);
        int rt  = int'(ins[3:2]);
        int rd  = int'(ins[1:0]);
        int imm = ins[1] ? int'(ins[1:0]) - 4 : int'(ins[1:0]);
        int off = ins[5] ? int'(ins[5:0]) - 64 : int'(ins[5:0]);
        int a   = (m_r[rs] + imm) & 31;
        e.lat = (op == 1) ? 2 : 1;
        case (op)
            0: m_r[rd] = (m_r[rs] + m_r[rt]) & 255;
            1: m_r[rt] = m_mem[a];
            2: m_mem[a] = m_r[rt];
            default: ;
        endcase
        m_pc = (m_pc + 1 + (op == 3 ? off : 0)) & 255;
        e.pc = m_pc;
        for (int i = 0; i < 4; i++) e.r[i] = 8'(m_r[i]);
    endtask

    task automatic check_model(input string tag);
        check({tag, "_ready"}, int'(instr_ready), 1);
        check({tag, "_retire"}, int'(retire), 0);
        check({tag, "_pc"}, int'(read_address), m_pc);
        for (int i = 0; i < 4; i++) begin
            reg_sel = 2'(i);
            #1;
            check($sformatf("%s_r%0d", tag, i), int'(reg_out), m_r[i]);
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clock);
        reset = 1'b1;
        instr_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        model_reset();
        check_model(tag);
    endtask

    task automatic issue(input logic [7:0] ins);
        exp_t e;
        int n = 0;
        model_step(ins, e);
        sb.push_back(e);
        check($sformatf("ready_%h", ins), int'(instr_ready), 1);
        Instruction = ins;
        instr_valid = 1'b1;
        do begin
            @(negedge clock);
            n++;
            if (n == 1) check($sformatf("busy_%h", ins), int'(instr_ready), 0);
            // Keep offering a junk jump while busy: the core must ignore it.
            if (retire) instr_valid = 1'b0;
            else Instruction = 8'hFF;
        end while (!retire && n < 8);
        instr_valid = 1'b0;
        e = sb.pop_front();
        check($sformatf("latency_%h", ins), n, e.lat);
        @(negedge clock);
        check($sformatf("pulse_%h", ins), int'(retire), 0);
        check($sformatf("pc_%h", ins), int'(read_address), e.pc);
        check($sformatf("pc16_%h", ins), int'(read_address16), e.pc);
        for (int i = 0; i < 4; i++) begin
            reg_sel = 2'(i);
            #1;
            check($sformatf("r%0d_%h", i, ins), int'(reg_out), int'(e.r[i]));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] preload [10] = '{8'h4F, 8'h3C, 8'h00, 8'h00, 8'h26,
                                     8'h2A, 8'h26, 8'h08, 8'h91, 8'h51};
        model_reset();

        do_reset("idle");
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            check("idle_ready", int'(instr_ready), 1);
            check("idle_retire", int'(retire), 0);
        end
        check_model("idle_end");

        do_reset("add");
        issue(8'h38);
        issue(8'hB1);
        issue(8'h79);
        check("lw_r2_const", int'(reg_out), int'(reg_sel == 2'd3 ? m_r[3] : 5));

        do_reset("jump");
        issue(8'hFE);
        check("j_back_const", int'(read_address), 255);
        issue(8'hC3);
        check("j_fwd_const", int'(read_address), 3);

        do_reset("lw_neg");
        issue(8'h4F);
        reg_sel = 2'd3;
        #1;
        check("lw_wrap_const", int'(reg_out), 31);

        do_reset("abort");
        Instruction = 8'h4F;
        instr_valid = 1'b1;
        @(negedge clock);
        instr_valid = 1'b0;
        check("abort_exec_retire", int'(retire), 0);
        @(negedge clock);
        check("abort_mem_retire", int'(retire), 1);
        reset = 1'b1;
        #1;
        check("abort_masked_retire", int'(retire), 0);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        check_model("abort_after");

        do_reset("wrap");
        foreach (preload[k]) issue(preload[k]);
        reg_sel = 2'd0;
        #1;
        check("preload_r0", int'(reg_out), 255);
        check("preload16_r0", int'(reg_out16), 255);
        issue(8'h05);
        reg_sel = 2'd1;
        #1;
        check("wrap8_r1", int'(reg_out), 0);
        check("wrap16_r1", int'(reg_out16), 256);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/param_cpu_core.md
PARAM_CPU_CORE -- requirements
Module: param_cpu_core

Interface
REQ-001 Parameter DATA_W, default 8: register and data-memory word width, legal range 4..32.
REQ-002 Parameter ADDR_W, default 8: program counter and read_address width.
REQ-003 Parameter DMEM_DEPTH, default 32: data-memory words, power of two, at most 2^DATA_W.
REQ-004 Port clock, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port Instruction, input, 8 bits: the instruction word addressed by read_address.
REQ-007 Port instr_valid, input, 1 bit: Instruction is valid this cycle.
REQ-008 Port instr_ready, output, 1 bit: the core is in the FETCH state and accepts an instruction.
REQ-009 Port read_address, output, ADDR_W bits: current PC, registered.
REQ-010 Port reg_sel, input, 2 bits: register index for debug readout.
REQ-011 Port reg_out, output, DATA_W bits: R[reg_sel], combinational from the register file.
REQ-012 Port retire, output, 1 bit: one-cycle pulse on the cycle an instruction completes.

Function
REQ-013 Instruction encoding: op=[7:6]. ADD/LW/SW use rs=[5:4] and rt=[3:2]. ADD uses rd=[1:0]. LW/SW use imm=[1:0], signed. J uses off=[5:0], signed.
REQ-014 ADD (00) SHALL perform R[rd] <= (R[rs]+R[rt]) mod 2^DATA_W; carry is discarded.
REQ-015 LW (01) SHALL perform R[rt] <= dmem[(R[rs]+sext(imm)) mod DMEM_DEPTH].
REQ-016 SW (10) SHALL perform dmem[(R[rs]+sext(imm)) mod DMEM_DEPTH] <= R[rt].
REQ-017 J (11) SHALL perform PC <= (PC+1+sext(off)) mod 2^ADDR_W; all other instructions set PC <= (PC+1) mod 2^ADDR_W.
REQ-018 There SHALL be four registers, R0..R3, with no hardwired zero register.
REQ-019 The FSM SHALL have three states: FETCH, EXEC and MEM.
REQ-020 FETCH: if instr_valid=1, latch Instruction into the IR and go to EXEC; otherwise stay in FETCH with PC and registers held.
REQ-021 EXEC: ADD, SW and J SHALL commit, update PC, pulse retire and go to FETCH. LW SHALL register the memory address and go to MEM.
REQ-022 MEM: LW writes R[rt], updates PC, pulses retire and goes to FETCH.
REQ-023 Latency from acceptance to retire SHALL be 1 cycle for ADD/SW/J and 2 cycles for LW. Throughput is one instruction per 2 or 3 cycles.
REQ-024 instr_ready SHALL be 1 only in FETCH. Instruction is ignored in all other states.
REQ-025 The read_address update SHALL be visible in the cycle after retire; the next fetch uses the new PC.
REQ-026 An ADD or LW whose destination is also a source SHALL read the old value and write the new one.

Reset
REQ-027 When reset=1 at an edge, the core SHALL set: state=FETCH, PC=0, retire=0, R[i]=i, dmem[i]=i mod 2^DATA_W for every i.
REQ-028 Reset asserted in EXEC or MEM SHALL abort the instruction with no register, memory or PC write from it. Reset has priority over every other event.
REQ-029 After reset deasserts, instr_ready SHALL be 1 in the first cycle.

Structure
REQ-030 Shared package cpu_pkg SHALL hold the opcode constants (OP_ADD/OP_LW/OP_SW/OP_J), the FSM state type, and field-position constants.
REQ-031 The data memory SHALL be the sub-module cpu_dmem (DATA_W, DMEM_DEPTH) with a synchronous write, a registered read, and reset initialisation. The register file and FSM stay in param_cpu_core.

Verification (defaults DATA_W=8, ADDR_W=8, DMEM_DEPTH=32)
REQ-032 Reset, then 0x38 (ADD R0=R3+R2) with instr_valid=1 -> retire one cycle after acceptance; reg_sel=0 gives reg_out=5; read_address=1.
REQ-033 After REQ-032, issue 0xB1 (SW mem[R3+1]=R0) then 0x79 (LW R2=mem[R3+1]) -> LW retires 2 cycles after acceptance; R2=5; read_address=3.
REQ-034 Reset, then 0xFE (J -2) at PC 0 -> read_address=255. Then 0xC3 (J +3) -> read_address=3.
REQ-035 Hold instr_valid=0 for 10 cycles after reset -> instr_ready=1 throughout, read_address=0, R0..R3=0,1,2,3, no retire.
REQ-036 Reset, then 0x4F (LW R3=mem[R0-1]) -> R3=31. Repeat the run and assert reset in the MEM cycle -> R3=3, PC=0, state FETCH.
REQ-037 ADD wrap: set R0=255 via SW/LW preload, then 0x05 (R1=R0+R1) -> R1=0. Rerun with DATA_W=16 -> R1=256.
